// File: rtl/usb_pkg.sv
// Shared types and constants for the USB HID report path.
package usb_pkg;

    typedef logic [63:0] hid_report_t;

    // Boot-report field positions: modifiers, one reserved byte, six keycodes.
    localparam int HID_MOD_MSB  = 63;
    localparam int HID_MOD_LSB  = 56;
    localparam int HID_KEY0_MSB = 47;
    localparam int HID_KEY0_LSB = 40;
    localparam int HID_KEY1_MSB = 39;
    localparam int HID_KEY1_LSB = 32;
    localparam int HID_KEY2_MSB = 31;
    localparam int HID_KEY2_LSB = 24;
    localparam int HID_KEY3_MSB = 23;
    localparam int HID_KEY3_LSB = 16;
    localparam int HID_KEY4_MSB = 15;
    localparam int HID_KEY4_LSB = 8;
    localparam int HID_KEY5_MSB = 7;
    localparam int HID_KEY5_LSB = 0;

    // SoC register offsets; a read of the LSW generates the ack pulse.
    localparam logic [11:0] USB_REG_VALID = 12'h000;
    localparam logic [11:0] USB_REG_MSW   = 12'h004;
    localparam logic [11:0] USB_REG_LSW   = 12'h008;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through circular FIFO with separate occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok, pop_ok;

    // Handshake qualification and next-state for pointers, count and storage.
    always_comb begin
        full_o   = (count_q == DEPTH_C);
        empty_o  = (count_q == '0);
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale slots are never visible while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/usb_report_queue.sv
// HID boot-report queue between the USB host core and the SoC register view.
// Adds de-duplication of repeated reports, a sticky overflow flag and
// zeroing of the head report while empty on top of a plain FIFO.
module usb_report_queue
    import usb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DEDUP = 1
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  hid_report_t              report_i,
    input  logic                     report_strobe_i,
    input  logic                     ack_i,
    input  logic                     overflow_clr_i,
    output hid_report_t              usb_report_o,
    output logic                     usb_report_valid_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    hid_report_t last_report_q, last_report_d;
    logic        last_valid_q, last_valid_d;
    logic        overflow_q, overflow_d;
    logic        candidate, accept, drop;
    logic        fifo_full, fifo_empty;
    hid_report_t fifo_rdata;

    // Filter repeats, decide accept/drop and update de-dup and overflow state.
    always_comb begin
        candidate     = report_strobe_i &&
                        ((DEDUP == 0) || !last_valid_q || (report_i != last_report_q));
        accept        = candidate && (!fifo_full || ack_i);
        drop          = candidate && fifo_full && !ack_i;
        last_report_d = last_report_q;
        last_valid_d  = last_valid_q;
        overflow_d    = overflow_q;
        if (accept) begin
            last_report_d = report_i;
            last_valid_d  = 1'b1;
        end
        if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // De-dup history and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            last_report_q <= '0;
            last_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            last_report_q <= last_report_d;
            last_valid_q  <= last_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_i (reset_i),
        .push_i  (accept),
        .pop_i   (ack_i),
        .wdata_i (report_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    // Head is forced to zero while empty so the SoC never reads stale data.
    always_comb begin
        usb_report_o       = fifo_empty ? '0 : fifo_rdata;
        usb_report_valid_o = !fifo_empty;
        overflow_o         = overflow_q;
    end

endmodule
